// File: rtl/dual_issue_steer_if.sv
// Fetch-side pair handshake and the two registered decoder-slot outputs of the issue-steering stage.
interface dual_issue_steer_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic [31:0] fetch_pc;
  logic        issue_stall;
  logic        flush;
  logic [31:0] inst_A;
  logic [31:0] inst_B;
  logic        valid_A;
  logic        valid_B;
  logic [31:0] pc_A;
  logic [31:0] pc_B;
  logic        b_older;

  modport master (
    output fetch_valid, fetch_inst0, fetch_inst1, fetch_pc, issue_stall, flush,
    input  fetch_ready, inst_A, inst_B, valid_A, valid_B, pc_A, pc_B, b_older
  );

  modport slave (
    input  fetch_valid, fetch_inst0, fetch_inst1, fetch_pc, issue_stall, flush,
    output fetch_ready, inst_A, inst_B, valid_A, valid_B, pc_A, pc_B, b_older
  );
endinterface

// File: rtl/dual_issue_steer.sv
// In-order instruction queue steering up to two instructions/cycle into slot A (ALU/branch) and slot B (ALU/mem).
// A pair accepted at one edge can issue at the next; fetch_ready needs two free entries, issue_stall freezes the slots.
module dual_issue_steer #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input logic            clk,
  input logic            rst,
  dual_issue_steer_if.slave io
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PTR_TWO   = AW'(2);
  localparam logic [AW:0]   CNT_ZERO  = '0;
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_TWO   = (AW+1)'(2);
  localparam logic [AW:0]   READY_MAX = (AW+1)'(DEPTH - 2);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {PIPE_ANY, PIPE_A, PIPE_B} pipe_e;

  function automatic pipe_e pipe_of(input logic [6:0] op);
    case (op)
      OP_R, OP_I:         return PIPE_ANY;
      OP_LOAD, OP_STORE:  return PIPE_B;
      default:            return PIPE_A;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [31:0]   inst_a_q, inst_a_d, inst_b_q, inst_b_d;
  logic [31:0]   pc_a_q, pc_a_d, pc_b_q, pc_b_d;
  logic          valid_a_q, valid_a_d, valid_b_q, valid_b_d;
  logic          b_older_q, b_older_d;

  entry_t        head0, head1;
  pipe_e         pipe0, pipe1;
  logic [4:0]    rd0, rd1, rs1_1, rs2_1;
  logic          raw, waw, pair_ok, swap, enq;
  logic [AW:0]   deq_n;

  assign io.fetch_ready = (count_q <= READY_MAX);
  assign io.inst_A      = inst_a_q;
  assign io.inst_B      = inst_b_q;
  assign io.pc_A        = pc_a_q;
  assign io.pc_B        = pc_b_q;
  assign io.valid_A     = valid_a_q;
  assign io.valid_B     = valid_b_q;
  assign io.b_older     = b_older_q;

  // Hazard and pipe-conflict screening of the two oldest queued instructions.
  always_comb begin
    head0   = mem_q[rd_ptr_q];
    head1   = mem_q[rd_ptr_q + PTR_ONE];
    pipe0   = pipe_of(head0.inst[6:0]);
    pipe1   = pipe_of(head1.inst[6:0]);
    rd0     = head0.inst[11:7];
    rd1     = head1.inst[11:7];
    rs1_1   = head1.inst[19:15];
    rs2_1   = head1.inst[24:20];
    raw     = writes_rd(head0.inst[6:0]) && (rd0 != 5'd0) &&
              ((reads_rs1(head1.inst[6:0]) && (rs1_1 == rd0)) ||
               (reads_rs2(head1.inst[6:0]) && (rs2_1 == rd0)));
    waw     = writes_rd(head0.inst[6:0]) && writes_rd(head1.inst[6:0]) &&
              (rd0 != 5'd0) && (rd0 == rd1);
    pair_ok = (count_q >= CNT_TWO) && (head0.inst[6:0] != OP_BRANCH) &&
              !((pipe0 == PIPE_B) && (pipe1 == PIPE_B)) &&
              !((pipe0 == PIPE_A) && (pipe1 == PIPE_A)) && !raw && !waw;
    // Older instruction lands in B when it needs the memory pipe or the younger one needs the branch pipe.
    swap    = (pipe0 == PIPE_B) || (pipe1 == PIPE_A);
  end

  always_comb begin
    enq       = io.fetch_valid && io.fetch_ready && !io.flush;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    deq_n     = CNT_ZERO;
    inst_a_d  = inst_a_q;
    inst_b_d  = inst_b_q;
    pc_a_d    = pc_a_q;
    pc_b_d    = pc_b_q;
    valid_a_d = valid_a_q;
    valid_b_d = valid_b_q;
    b_older_d = b_older_q;

    if (enq) begin
      mem_d[wr_ptr_q]           = '{inst: io.fetch_inst0, pc: io.fetch_pc};
      mem_d[wr_ptr_q + PTR_ONE] = '{inst: io.fetch_inst1, pc: io.fetch_pc + 32'd4};
      wr_ptr_d                  = wr_ptr_q + PTR_TWO;
    end

    if (!io.issue_stall) begin
      inst_a_d  = NOP_INST;
      inst_b_d  = NOP_INST;
      pc_a_d    = '0;
      pc_b_d    = '0;
      valid_a_d = 1'b0;
      valid_b_d = 1'b0;
      b_older_d = 1'b0;
      if (count_q == CNT_ZERO) begin
        deq_n = CNT_ZERO;
      end else if (pair_ok) begin
        deq_n     = CNT_TWO;
        valid_a_d = 1'b1;
        valid_b_d = 1'b1;
        b_older_d = swap;
        if (swap) begin
          inst_a_d = head1.inst;  pc_a_d = head1.pc;
          inst_b_d = head0.inst;  pc_b_d = head0.pc;
        end else begin
          inst_a_d = head0.inst;  pc_a_d = head0.pc;
          inst_b_d = head1.inst;  pc_b_d = head1.pc;
        end
      end else begin
        deq_n = CNT_ONE;
        if (pipe0 == PIPE_B) begin
          inst_b_d = head0.inst;  pc_b_d = head0.pc;  valid_b_d = 1'b1;
        end else begin
          inst_a_d = head0.inst;  pc_a_d = head0.pc;  valid_a_d = 1'b1;
        end
      end
      rd_ptr_d = rd_ptr_q + deq_n[AW-1:0];
    end

    count_d = count_q + (enq ? CNT_TWO : CNT_ZERO) - deq_n;

    if (io.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      inst_a_d  = NOP_INST;
      inst_b_d  = NOP_INST;
      pc_a_d    = '0;
      pc_b_d    = '0;
      valid_a_d = 1'b0;
      valid_b_d = 1'b0;
      b_older_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      inst_a_q  <= NOP_INST;
      inst_b_q  <= NOP_INST;
      pc_a_q    <= '0;
      pc_b_q    <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      b_older_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      inst_a_q  <= inst_a_d;
      inst_b_q  <= inst_b_d;
      pc_a_q    <= pc_a_d;
      pc_b_q    <= pc_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      b_older_q <= b_older_d;
    end
  end

  // Storage carries no reset: entries are only observed once count says they were written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_dual_issue_steer.sv
// Directed bench for dual_issue_steer: stimulus pushes expected slot contents into a queue,
// a monitor compares every issue cycle (and frozen/idle cycles) against it.
module tb_dual_issue_steer;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADD  = 32'h003100B3;
  localparam logic [31:0] LW   = 32'h00032283;
  localparam logic [31:0] SUB  = 32'h40508233;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] LUI7 = 32'h000013B7;
  localparam logic [31:0] LUI8 = 32'h00001437;
  localparam logic [31:0] ADDI9 = 32'h00000493;

  typedef struct packed {
    logic [31:0] ia;
    logic [31:0] pa;
    logic        va;
    logic [31:0] ib;
    logic [31:0] pb;
    logic        vb;
    logic        bo;
  } out_t;

  logic clk;
  logic rst;
  dual_issue_steer_if io();

  dual_issue_steer #(.DEPTH(8), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1);
  end

  function automatic out_t mk(input logic [31:0] ia, input logic [31:0] pa, input logic va,
                              input logic [31:0] ib, input logic [31:0] pb, input logic vb,
                              input logic bo);
    out_t o;
    o.ia = ia; o.pa = pa; o.va = va;
    o.ib = ib; o.pb = pb; o.vb = vb; o.bo = bo;
    return o;
  endfunction

  // The PC of an empty slot carries no meaning, so it is left out of the comparison.
  function automatic out_t norm(input out_t o);
    out_t r = o;
    if (!r.va) r.pa = '0;
    if (!r.vb) r.pb = '0;
    return r;
  endfunction

  function automatic out_t sample();
    return mk(io.inst_A, io.pc_A, io.valid_A, io.inst_B, io.pc_B, io.valid_B, io.b_older);
  endfunction

  task automatic cmp_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (norm(act) !== norm(exp)) begin
      n_fail++;
      $display("FAIL %s: got A=%h/%h/%b B=%h/%h/%b bo=%b, expected A=%h/%h/%b B=%h/%h/%b bo=%b",
               name, act.ia, act.pa, act.va, act.ib, act.pb, act.vb, act.bo,
               exp.ia, exp.pa, exp.va, exp.ib, exp.pb, exp.vb, exp.bo);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: tracks what the slot registers should hold after every edge.
  initial begin
    out_t cur;
    logic e_rst, e_flush, e_stall;
    cur = mk(NOP, 0, 1'b0, NOP, 0, 1'b0, 1'b0);
    forever begin
      @(posedge clk);
      e_rst   = rst;
      e_flush = io.flush;
      e_stall = io.issue_stall;
      @(negedge clk);
      if (e_rst || e_flush) begin
        cur = mk(NOP, 0, 1'b0, NOP, 0, 1'b0, 1'b0);
        cmp_out("cleared_slots", sample(), cur);
      end else if (e_stall) begin
        cmp_out("frozen_slots", sample(), cur);
      end else if (io.valid_A || io.valid_B) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got A=%h B=%h, expected no issue", io.inst_A, io.inst_B);
        end else begin
          cur = exp_q.pop_front();
          cmp_out("issue", sample(), cur);
        end
      end else begin
        cur = mk(NOP, 0, 1'b0, NOP, 0, 1'b0, 1'b0);
        cmp_out("idle_slots", sample(), cur);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    io.fetch_valid = 1'b1;
    io.fetch_inst0 = i0;
    io.fetch_inst1 = i1;
    io.fetch_pc    = pc;
    step();
    io.fetch_valid = 1'b0;
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return (32'(k) << 20) | (32'(10 + k) << 7) | 32'h13;
  endfunction

  function automatic logic [31:0] lw_k(input int k);
    return (32'(20 + k) << 7) | 32'h2003;
  endfunction

  // Fill pairs alternate (addi, lw) and (lw, addi); each dual-issues with addi on A.
  task automatic push_fill_pair(input int k, input logic [31:0] pc, input logic expect_it);
    if (k % 2 == 0) begin
      if (expect_it) exp_q.push_back(mk(addi_k(k), pc, 1'b1, lw_k(k), pc + 4, 1'b1, 1'b0));
      push_pair(addi_k(k), lw_k(k), pc);
    end else begin
      if (expect_it) exp_q.push_back(mk(addi_k(k), pc + 4, 1'b1, lw_k(k), pc, 1'b1, 1'b1));
      push_pair(lw_k(k), addi_k(k), pc);
    end
  endtask

  initial begin
    rst            = 1'b1;
    io.fetch_valid = 1'b0;
    io.fetch_inst0 = '0;
    io.fetch_inst1 = '0;
    io.fetch_pc    = '0;
    io.issue_stall = 1'b0;
    io.flush       = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_valid_A", 32'(io.valid_A), 32'd0);
    chk("reset_valid_B", 32'(io.valid_B), 32'd0);
    chk("reset_inst_A", io.inst_A, NOP);
    chk("reset_inst_B", io.inst_B, NOP);
    chk("reset_fetch_ready", 32'(io.fetch_ready), 32'd1);
    step();

    // Independent add + load pair: one-cycle latency, natural placement.
    exp_q.push_back(mk(ADD, 32'h100, 1'b1, LW, 32'h104, 1'b1, 1'b0));
    push_pair(ADD, LW, 32'h100);
    chk("latency_before", 32'(io.valid_A), 32'd0);
    step();
    chk("latency_after", 32'(io.valid_A), 32'd1);
    repeat (3) step();

    // RAW on x1 serialises into two single issues on A.
    exp_q.push_back(mk(ADD, 32'h200, 1'b1, NOP, 0, 1'b0, 1'b0));
    exp_q.push_back(mk(SUB, 32'h204, 1'b1, NOP, 0, 1'b0, 1'b0));
    push_pair(ADD, SUB, 32'h200);
    repeat (4) step();

    // Load followed by branch: swapped placement, B older.
    exp_q.push_back(mk(BEQ, 32'h304, 1'b1, LW, 32'h300, 1'b1, 1'b1));
    push_pair(LW, BEQ, 32'h300);
    repeat (4) step();

    // Two A-only instructions cannot pair; then ANY + A-only swaps.
    exp_q.push_back(mk(LUI7, 32'h600, 1'b1, NOP, 0, 1'b0, 1'b0));
    exp_q.push_back(mk(LUI8, 32'h604, 1'b1, NOP, 0, 1'b0, 1'b0));
    push_pair(LUI7, LUI8, 32'h600);
    repeat (4) step();
    exp_q.push_back(mk(LUI8, 32'h704, 1'b1, ADDI9, 32'h700, 1'b1, 1'b1));
    push_pair(ADDI9, LUI8, 32'h700);
    repeat (4) step();

    // Fill to capacity under stall, then drain in order.
    io.issue_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill_ready_%0d", k), 32'(io.fetch_ready), 32'd1);
      push_fill_pair(k, 32'h400 + 32'(8 * k), 1'b1);
    end
    chk("full_ready", 32'(io.fetch_ready), 32'd0);
    io.fetch_valid = 1'b1;
    io.fetch_inst0 = ADD;
    io.fetch_inst1 = LW;
    io.fetch_pc    = 32'hBAD0;
    step();
    chk("full_ready_held", 32'(io.fetch_ready), 32'd0);
    io.fetch_valid = 1'b0;
    io.issue_stall = 1'b0;
    repeat (6) step();
    chk("drained_ready", 32'(io.fetch_ready), 32'd1);

    // Flush with six queued and a pair offered in the same cycle.
    exp_q.push_back(mk(ADD, 32'h800, 1'b1, LW, 32'h804, 1'b1, 1'b0));
    push_pair(ADD, LW, 32'h800);
    step();
    io.issue_stall = 1'b1;
    for (int k = 0; k < 3; k++) push_fill_pair(k, 32'h810 + 32'(8 * k), 1'b0);
    chk("pre_flush_valid_A", 32'(io.valid_A), 32'd1);
    io.flush       = 1'b1;
    io.fetch_valid = 1'b1;
    io.fetch_inst0 = ADD;
    io.fetch_inst1 = LW;
    io.fetch_pc    = 32'h8F0;
    step();
    io.flush       = 1'b0;
    io.fetch_valid = 1'b0;
    chk("flush_valid_A", 32'(io.valid_A), 32'd0);
    chk("flush_valid_B", 32'(io.valid_B), 32'd0);
    chk("flush_inst_A", io.inst_A, NOP);
    chk("flush_inst_B", io.inst_B, NOP);
    chk("flush_ready", 32'(io.fetch_ready), 32'd1);
    io.issue_stall = 1'b0;
    repeat (4) step();

    // Queue restarts cleanly after the flush.
    exp_q.push_back(mk(ADD, 32'h900, 1'b1, LW, 32'h904, 1'b1, 1'b0));
    push_pair(ADD, LW, 32'h900);
    repeat (4) step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_issue_steer.md
Name: dual_issue_steer

Overview:
- Instruction queue and issue-steering stage directly upstream of the two decoder slots.
- Accepts instruction pairs from fetch and buffers them in an in-order FIFO.
- Each cycle it issues up to two instructions into registered slot A (ALU/branch pipe) and slot B (ALU/memory pipe).
- It serialises any pair that has a pipe conflict or an intra-pair register hazard.

Parameters:
- DEPTH, 8, queue capacity in instructions; power of 2, minimum 4.
- NOP_INST, 32'h00000013, word driven on an empty slot (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch presents a pair this cycle.
- fetch_ready  out  1  queue can accept a pair.
- fetch_inst0  in  32  older instruction of the pair.
- fetch_inst1  in  32  younger instruction of the pair.
- fetch_pc  in  32  PC of fetch_inst0; fetch_inst1 is at fetch_pc+4.
- issue_stall  in  1  downstream hold.
- flush  in  1  branch redirect; discard all queued and issued-slot contents.
- inst_A  out  32  instruction for the ALU/branch decoder.
- inst_B  out  32  instruction for the ALU/memory decoder.
- valid_A  out  1  inst_A is a live instruction.
- valid_B  out  1  inst_B is a live instruction.
- pc_A  out  32  PC of inst_A.
- pc_B  out  32  PC of inst_B.
- b_older  out  1  both slots valid and inst_B precedes inst_A in program order.

Behaviour:
- Reset: when rst is high at a clock edge:
  - Queue empties.
  - inst_A = inst_B = NOP_INST.
  - valid_A = valid_B = b_older = 0; pc_A = pc_B = 0.
  - fetch_ready reads 1 in the following cycle.
  - Reset overrides flush, stall and fetch.
- Enqueue:
  - fetch_ready = (free entries >= 2), computed from the registered count only; it ignores same-cycle dequeue.
  - On fetch_valid && fetch_ready && !flush, both words are written at the edge (inst0 first) with PCs fetch_pc and fetch_pc+4.
  - fetch_valid while !fetch_ready is ignored; fetch must hold the pair.
- Classification by opcode [6:0]:
  - 0110011 (R) and 0010011 (I): ANY pipe.
  - 1100011 (branch): A-only.
  - 0000011 (load) and 0100011 (store): B-only.
  - Any other opcode: A-only.
- Register use:
  - Writes rd: R, I, load.
  - Reads rs1: R, I, load, store, branch.
  - Reads rs2: R, store, branch.
- Issue decision: evaluated combinationally from head entries i0 (older) and i1 when !issue_stall.
  - Nothing queued: both slots load NOP_INST with valid 0.
  - Pair issue requires all of the following:
    - count >= 2.
    - i0 not a branch.
    - Not both B-only, and not both A-only.
    - No RAW: i0 writes rd != x0 and i1 reads that register.
    - No WAW: both write the same rd != x0.
  - Pair placement:
    - i0 B-only: i0 to B, i1 to A, b_older = 1.
    - i1 B-only: i0 to A, i1 to B.
    - i1 A-only: i0 to B, i1 to A, b_older = 1.
    - Both ANY: i0 to A, i1 to B.
  - Single issue: i0 goes to A if ANY or A-only, otherwise to B; the other slot gets NOP_INST with valid 0; b_older = 0.
- Timing:
  - Output registers and dequeue (1 or 2 entries) update at the edge.
  - A pair accepted at edge k is issuable at edge k+1, so its earliest output is visible after edge k+1.
  - Peak throughput is 2 instructions/cycle.
- Stall: while issue_stall is high, outputs hold and no dequeue occurs; enqueue still proceeds if fetch_ready.
- Flush: at the edge, the queue empties and both slots go NOP_INST/invalid, regardless of stall. A fetch offered in a flush cycle is dropped.
- Pointers: wrap modulo DEPTH; the count is DEPTH+1 states wide; simultaneous enqueue of 2 and dequeue of 1 or 2 is exact.
- Order: program order is preserved; i1 never issues without i0.

Test Plan:
- Reset: hold rst 2 cycles → valid_A = valid_B = 0, inst_A = inst_B = 32'h00000013, fetch_ready = 1.
- Pair, no conflict: add x1,x2,x3 (32'h003100B3) + lw x5,0(x6) (32'h00032283) at pc 0x100.
  - Required response one cycle later: inst_A = 003100B3 with pc_A = 0x100; inst_B = 00032283 with pc_B = 0x104; b_older = 0.
- RAW: 32'h003100B3 then sub x4,x1,x5 (32'h40508233).
  - Required response: add is issued alone on A; next cycle sub is issued alone on A; valid_B = 0 both cycles.
- Mem-then-branch: lw x5,0(x6) + beq x1,x2,+8 (32'h00208463).
  - Required response: same cycle inst_B = lw, inst_A = beq, b_older = 1.
- Fill/stall: hold issue_stall = 1 and push 4 pairs with DEPTH = 8.
  - Required response: fetch_ready drops to 0 after the 4th pair and outputs stay frozen; releasing the stall drains all 8 instructions in order.
- Flush: with 6 queued instructions, assert flush together with fetch_valid.
  - Required response: next cycle both slots invalid and NOP, queue empty, offered pair not enqueued.
